plic_irq_cond: RTL and testbench
================================

Name: plic_irq_cond

Overview:
Interrupt source conditioner placed directly upstream of the PLIC top. It receives raw asynchronous interrupt lines and passes each one through a synchronizer, a polarity stage and a per-source glitch filter. Each line is then emitted as either a clean level or a single-cycle edge pulse on irq_sources_o. A registered le_o travels alongside so the PLIC gateways know which mode each source is in.

Parameters:
N_SOURCE, 30, number of interrupt sources (matches PLIC N_SOURCE)
SYNC_STAGES, 2, synchronizer flops per source (legal range 2..4)
FILT_W, 4, width of the glitch-filter length and of each per-source counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
irq_raw_i  in  N_SOURCE  raw asynchronous interrupt lines
pol_i  in  N_SOURCE  per-source polarity; 1 = active-low (inverted after sync)
mode_i  in  N_SOURCE  per-source mode; 0 = level, 1 = edge
filt_len_i  in  FILT_W  shared filter length; 0 = filter bypassed
irq_sources_o  out  N_SOURCE  conditioned interrupts, to PLIC irq_sources_i
le_o  out  N_SOURCE  registered copy of mode_i, to PLIC le_i

Behaviour:
- Clocking/reset: single clock domain on clk_i. rst_i is synchronous and active-high.
- Reset values: all sync flops, filter state, counters, edge history, irq_sources_o and le_o are 0.
- Synchronizer: SYNC_STAGES flop chain per source. s = last stage XOR pol_i.
- Filter, per source, holding state f and counter c:
  - s == f: c <= 0.
  - s != f and c >= filt_len_i: f <= s, c <= 0.
  - Otherwise: c <= c + 1, saturating at all-ones.
  - filt_len_i == 0: f follows s with 1 cycle of delay.
  - Net effect: a change on s must persist for filt_len_i+1 consecutive cycles before f toggles. Shorter glitches are dropped and c restarts.
- Changing filt_len_i mid-count: the >= comparison takes effect on the next cycle. No counter flush.
- Level mode (mode=0): irq_sources_o <= f. Latency from an irq_raw_i edge to output = SYNC_STAGES + filt_len_i + 2 cycles.
- Edge mode (mode=1): irq_sources_o <= f & ~f_d, a one-cycle pulse per filtered rising edge, with the same latency. Falling edges produce nothing.
- Edge history: f_d <= f every cycle regardless of mode. Switching mode therefore never creates a spurious pulse, except that level-to-edge while f=1 produces no pulse.
- le_o <= mode_i, registered to stay aligned with irq_sources_o.
- Polarity change mid-operation: treated as an input transition and subject to the filter.
- Reset mid-operation: everything clears on the next edge. A line still asserted after reset re-qualifies through sync and filter, and in edge mode produces one fresh pulse.
- Independence: sources never interact. All counters are FILT_W bits wide, so no overflow is possible beyond saturation.

Optional Feature:
Macro: PLIC_IRQ_COND_STATUS_EN.
- Defined: adds input stat_clr_i[N_SOURCE] and output stat_o[N_SOURCE].
  - stat_o[i] is sticky-set on any cycle where irq_sources_o[i] is 1.
  - stat_o[i] is cleared by stat_clr_i[i].
  - Same-cycle set and clear: set wins.
  - Reset value 0.
- Undefined: these ports and their logic are absent. Core behaviour is identical either way.

Test Plan:
1. Bypass level: filt_len=0, mode=0, pol=0, SYNC_STAGES=2. irq_raw_i[3] rises at cycle 0 → irq_sources_o[3]=1 at cycle 4, and falls 4 cycles after raw falls.
2. Glitch reject: filt_len=3, 3-cycle high pulse on source 5 → irq_sources_o[5] stays 0. A 4-cycle pulse → output high at cycle 2+3+2=7 after the raw rise.
3. Edge mode: mode[0]=1, filt_len=0, raw held high for 20 cycles → exactly one 1-cycle pulse at cycle 4, and no pulse on the falling edge.
4. Polarity: pol[7]=1 with raw[7]=1 → output 0. Raw drops to 0 → output 1 after 4 cycles. Flipping pol with raw static → one transition after filtering.
5. Reset mid-operation: raw[2]=1, edge mode, rst_i asserted for 1 cycle after the first pulse → all outputs 0 during reset, then one new pulse 4 cycles after reset deasserts.
6. With PLIC_IRQ_COND_STATUS_EN: pulse sets stat_o[1]. stat_clr_i[1] asserted in the same cycle as a new pulse → stat_o[1] stays 1. A later clear → 0.

Source files
------------

// File: rtl/plic_irq_cond.sv
// plic_irq_cond: per-source sync, polarity, glitch filter and level/edge
// shaping of raw interrupt lines ahead of the PLIC gateways.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   irq_raw_i      raw asynchronous interrupt lines
//   pol_i          1 = source is active-low
//   mode_i         0 = level, 1 = edge (rising-edge pulse)
//   filt_len_i     filter length, 0 = bypass
//   irq_sources_o  conditioned interrupts to PLIC
//   le_o           registered mode_i, aligned with irq_sources_o
//   stat_clr_i     sticky status clear   (PLIC_IRQ_COND_STATUS_EN only)
//   stat_o         sticky status         (PLIC_IRQ_COND_STATUS_EN only)
//
// Optional feature macro: PLIC_IRQ_COND_STATUS_EN
module plic_irq_cond #(
  parameter int N_SOURCE    = 30,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] irq_raw_i,
  input  logic [N_SOURCE-1:0] pol_i,
  input  logic [N_SOURCE-1:0] mode_i,
  input  logic [FILT_W-1:0]   filt_len_i,
`ifdef PLIC_IRQ_COND_STATUS_EN
  input  logic [N_SOURCE-1:0] stat_clr_i,
  output logic [N_SOURCE-1:0] stat_o,
`endif
  output logic [N_SOURCE-1:0] irq_sources_o,
  output logic [N_SOURCE-1:0] le_o
);

  logic [SYNC_STAGES-1:0] sync_q [N_SOURCE];
  logic [FILT_W-1:0]      cnt_q  [N_SOURCE];
  logic [N_SOURCE-1:0]    filt_q;
  logic [N_SOURCE-1:0]    filt_d_q;
  logic [N_SOURCE-1:0]    s;
  logic [N_SOURCE-1:0]    shaped;

  // Polarity applied after the chain so the
  // synchronizer only ever sees raw pins.
  always_comb begin
    s = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1] ^ pol_i[i];
    end
  end

  // Edge pulse uses filter history kept in
  // both modes, so mode switches stay clean.
  always_comb begin
    shaped = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      shaped[i] = mode_i[i] ? (filt_q[i] & ~filt_d_q[i])
                            : filt_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_SOURCE; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      filt_q        <= '0;
      filt_d_q      <= '0;
      irq_sources_o <= '0;
      le_o          <= '0;
    end else begin
      for (int i = 0; i < N_SOURCE; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0],
                      irq_raw_i[i]};
        if (s[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] >= filt_len_i) begin
          filt_q[i] <= s[i];
          cnt_q[i]  <= '0;
        end else if (cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + FILT_W'(1);
        end
      end
      filt_d_q      <= filt_q;
      irq_sources_o <= shaped;
      le_o          <= mode_i;
    end
  end

`ifdef PLIC_IRQ_COND_STATUS_EN
  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_o <= '0;
    end else begin
      stat_o <= (stat_o & ~stat_clr_i) | irq_sources_o;
    end
  end
`endif

endmodule

// File: tb/tb_plic_irq_cond.sv
// tb_plic_irq_cond: directed self-checking bench for plic_irq_cond.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_plic_irq_cond;

  localparam int N = 30;
  localparam int FW = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  raw;
  logic [N-1:0]  pol;
  logic [N-1:0]  mode;
  logic [FW-1:0] filt;
  logic [N-1:0]  irq;
  logic [N-1:0]  le;
`ifdef PLIC_IRQ_COND_STATUS_EN
  logic [N-1:0]  stat_clr;
  logic [N-1:0]  stat;
`endif

  int total = 0;
  int bad = 0;

  plic_irq_cond #(
    .N_SOURCE(N), .SYNC_STAGES(2), .FILT_W(FW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .irq_raw_i(raw),
    .pol_i(pol),
    .mode_i(mode),
    .filt_len_i(filt),
`ifdef PLIC_IRQ_COND_STATUS_EN
    .stat_clr_i(stat_clr),
    .stat_o(stat),
`endif
    .irq_sources_o(irq),
    .le_o(le)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [N-1:0] obs,
                     input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    raw  = '0;
    pol  = '0;
    mode = '0;
    filt = '0;
`ifdef PLIC_IRQ_COND_STATUS_EN
    stat_clr = '0;
`endif
    tick(2);
    chk("reset_irq", irq, '0);
    chk("reset_le", le, '0);
    rst = 1'b0;
    tick(2);

    // bypass level on source 3
    raw[3] = 1'b1;
    tick(3);
    chk("t1_rise_early", irq, '0);
    tick(1);
    chk("t1_rise", irq, N'(1) << 3);
    raw[3] = 1'b0;
    tick(3);
    chk("t1_fall_early", irq, N'(1) << 3);
    tick(1);
    chk("t1_fall", irq, '0);

    // glitch filter, length 3, source 5
    filt = 4'd3;
    raw[5] = 1'b1;
    tick(3);
    raw[5] = 1'b0;
    tick(10);
    chk("t2_glitch", irq, '0);
    raw[5] = 1'b1;
    tick(6);
    chk("t2_pass_early", irq, '0);
    tick(1);
    chk("t2_pass", irq, N'(1) << 5);
    raw[5] = 1'b0;
    tick(10);
    chk("t2_clear", irq, '0);

    // edge mode on source 0
    filt = '0;
    mode[0] = 1'b1;
    tick(1);
    chk("t3_le", le, N'(1));
    raw[0] = 1'b1;
    tick(3);
    chk("t3_pre", irq, '0);
    tick(1);
    chk("t3_pulse", irq, N'(1));
    tick(1);
    chk("t3_pulse_end", irq, '0);
    tick(15);
    chk("t3_hold", irq, '0);
    raw[0] = 1'b0;
    begin
      logic [N-1:0] acc;
      acc = '0;
      for (int k = 0; k < 8; k++) begin
        tick(1);
        acc = acc | irq;
      end
      chk("t3_no_fall_pulse", acc, '0);
    end

    // polarity on source 7; short sync glitch
    // from the simultaneous change is filtered
    filt = 4'd3;
    pol[7] = 1'b1;
    raw[7] = 1'b1;
    tick(10);
    chk("t4_inv_high", irq, '0);
    filt = '0;
    raw[7] = 1'b0;
    tick(3);
    chk("t4_low_early", irq, '0);
    tick(1);
    chk("t4_low", irq, N'(1) << 7);
    pol[7] = 1'b0;
    tick(1);
    chk("t4_polflip_early", irq, N'(1) << 7);
    tick(1);
    chk("t4_polflip", irq, '0);

    // filter length shrunk mid-count, source 9
    filt = 4'd15;
    raw[9] = 1'b1;
    tick(10);
    chk("t7_long", irq, '0);
    filt = 4'd2;
    tick(1);
    chk("t7_shrink_early", irq, '0);
    tick(1);
    chk("t7_shrink", irq, N'(1) << 9);
    raw[9] = 1'b0;
    filt = '0;
    tick(5);
    chk("t7_clear", irq, '0);

    // reset mid-operation, edge mode source 2
    mode[2] = 1'b1;
    raw[2] = 1'b1;
    tick(4);
    chk("t5_pulse", irq, N'(1) << 2);
    tick(1);
    chk("t5_pulse_end", irq, '0);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_irq", irq, '0);
    chk("t5_rst_le", le, '0);
    rst = 1'b0;
    tick(3);
    chk("t5_re_early", irq, '0);
    chk("t5_re_le", le, N'(5));
    tick(1);
    chk("t5_re_pulse", irq, N'(1) << 2);
    tick(1);
    chk("t5_re_end", irq, '0);

`ifdef PLIC_IRQ_COND_STATUS_EN
    stat_clr = '1;
    tick(1);
    stat_clr = '0;
    chk("t6_clr_all", stat, '0);
    mode[1] = 1'b1;
    raw[1] = 1'b1;
    tick(5);
    chk("t6_set", stat, N'(1) << 1);
    raw[1] = 1'b0;
    tick(5);
    raw[1] = 1'b1;
    tick(4);
    chk("t6_pulse2", irq, N'(1) << 1);
    stat_clr[1] = 1'b1;
    tick(1);
    chk("t6_set_wins", stat, N'(1) << 1);
    tick(1);
    chk("t6_clear", stat, '0);
    stat_clr = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
